// File: rtl/driver_monitor_pkg.sv
// Shared definitions for the driver-monitor pipeline.
// Holds the default score width and averaging window, plus the
// score_averager state encoding. The downstream safety FSM imports
// SC_W_DEFAULT from here so both stages agree on the score width.
package driver_monitor_pkg;

  localparam int SC_W_DEFAULT     = 8;
  localparam int WIN_LOG2_DEFAULT = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FILL  = 2'b01,
    RUN   = 2'b10
  } avg_state_t;

endpackage

// File: rtl/score_averager_if.sv
// Sample/average bus between the score producer and score_averager.
// Signals:
//   clear        : synchronous window flush, active high
//   sample_valid : sample_sc carries a new score this cycle
//   sample_sc    : instantaneous drowsiness score
//   avg_sc       : registered moving average
//   avg_valid    : window holds N real samples
//   fill_cnt     : samples held in the window, saturating at N
//   state        : averager FSM state (observation only)
//   peak_sc      : peak RUN-phase average (only with SCORE_PEAK_HOLD_EN)
// Handshake: one-way valid strobe. A sample is taken on every rising clk
// edge where sample_valid=1 and clear=0; there is no ready, the averager
// always accepts. clear takes priority and drops a coincident sample.
// Modports: master = producer / consumer side, slave = score_averager.
interface score_averager_if
  import driver_monitor_pkg::*;
#(
  parameter int SC_W     = SC_W_DEFAULT,
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) ();

  logic                clear;
  logic                sample_valid;
  logic [SC_W-1:0]     sample_sc;
  logic [SC_W-1:0]     avg_sc;
  logic                avg_valid;
  logic [WIN_LOG2:0]   fill_cnt;
  avg_state_t          state;
`ifdef SCORE_PEAK_HOLD_EN
  logic [SC_W-1:0]     peak_sc;
`endif

  modport master (
    output clear, sample_valid, sample_sc,
    input  avg_sc, avg_valid, fill_cnt, state
`ifdef SCORE_PEAK_HOLD_EN
    , input peak_sc
`endif
  );

  modport slave (
    input  clear, sample_valid, sample_sc,
    output avg_sc, avg_valid, fill_cnt, state
`ifdef SCORE_PEAK_HOLD_EN
    , output peak_sc
`endif
  );

endinterface

// File: rtl/score_ring_buf.sv
// N-entry ring buffer of past scores for the moving average.
// Returns the entry about to be overwritten (o_old); unwritten slots read 0
// because reset and clear zero the whole array.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   i_clear    : zero all entries and the write pointer
//   i_wr_en    : store i_wr_data at the write pointer and advance it
//   i_wr_data  : score to store
//   o_old      : current content of the slot at the write pointer
module score_ring_buf #(
  parameter int SC_W     = 8,
  parameter int WIN_LOG2 = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_wr_en,
  input  logic [SC_W-1:0] i_wr_data,
  output logic [SC_W-1:0] o_old
);

  localparam int N = 1 << WIN_LOG2;

  logic [SC_W-1:0]     r_buf [N];
  logic [WIN_LOG2-1:0] r_wr_ptr;

  // Pointer is exactly WIN_LOG2 bits, so N-1 -> 0 wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_wr_ptr <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_wr_ptr <= '0;
    end else if (i_wr_en) begin
      r_buf[r_wr_ptr] <= i_wr_data;
      r_wr_ptr        <= r_wr_ptr + WIN_LOG2'(1);
    end
  end

  assign o_old = r_buf[r_wr_ptr];

endmodule

// File: rtl/score_averager.sv
// Moving average of drowsiness scores over a 2^WIN_LOG2 sample window.
// avg_sc = window sum >> WIN_LOG2, registered one clock after the sample.
// During start-up the window is zero-padded, so avg_sc ramps while
// avg_valid=0; avg_valid rises together with the first full-window average.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : score_averager_if.slave (clear, sample in; avg, flags, state out)
// Optional feature: define SCORE_PEAK_HOLD_EN to add bus.peak_sc, the
// maximum average seen once the window is full.
module score_averager
  import driver_monitor_pkg::*;
#(
  parameter int SC_W     = SC_W_DEFAULT,
  parameter int WIN_LOG2 = WIN_LOG2_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  score_averager_if.slave  bus
);

  localparam int SUM_W = SC_W + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = {1'b0, {WIN_LOG2{1'b1}}};

  logic [SUM_W-1:0] r_sum;
  logic [SC_W-1:0]  r_avg_sc;
  logic             r_avg_valid;
  logic [CNT_W-1:0] r_fill_cnt;
  avg_state_t       r_state;

  logic             w_accept;
  logic [SC_W-1:0]  w_old;
  logic [SUM_W-1:0] w_new_sum;
  logic             w_run_next;

  assign w_accept = bus.sample_valid && !bus.clear;

  score_ring_buf #(
    .SC_W     (SC_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_ring_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (bus.clear),
    .i_wr_en   (w_accept),
    .i_wr_data (bus.sample_sc),
    .o_old     (w_old)
  );

  // w_old is already part of r_sum, so the subtraction cannot underflow.
  assign w_new_sum = r_sum + {{WIN_LOG2{1'b0}}, bus.sample_sc}
                           - {{WIN_LOG2{1'b0}}, w_old};

  // The accepted sample lands in RUN: either already there, or it is the
  // sample that completes the window.
  assign w_run_next = (r_state == RUN) ||
                      ((r_state == FILL) && (r_fill_cnt == LAST_CNT));

`ifdef SCORE_PEAK_HOLD_EN
  logic [SC_W-1:0] r_peak_sc;
  assign bus.peak_sc = r_peak_sc;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum       <= '0;
      r_avg_sc    <= '0;
      r_avg_valid <= 1'b0;
      r_fill_cnt  <= '0;
      r_state     <= EMPTY;
`ifdef SCORE_PEAK_HOLD_EN
      r_peak_sc   <= '0;
`endif
    end else if (bus.clear) begin
      r_sum       <= '0;
      r_avg_sc    <= '0;
      r_avg_valid <= 1'b0;
      r_fill_cnt  <= '0;
      r_state     <= EMPTY;
`ifdef SCORE_PEAK_HOLD_EN
      r_peak_sc   <= '0;
`endif
    end else if (w_accept) begin
      r_sum    <= w_new_sum;
      r_avg_sc <= w_new_sum[SUM_W-1:WIN_LOG2];
      case (r_state)
        EMPTY: begin
          r_fill_cnt <= CNT_W'(1);
          r_state    <= FILL;
        end
        FILL: begin
          r_fill_cnt <= r_fill_cnt + CNT_W'(1);
          if (r_fill_cnt == LAST_CNT) begin
            r_state     <= RUN;
            r_avg_valid <= 1'b1;
          end
        end
        RUN: begin
          r_fill_cnt  <= FULL_CNT;
          r_avg_valid <= 1'b1;
        end
        default: begin
          r_fill_cnt  <= '0;
          r_avg_valid <= 1'b0;
          r_state     <= EMPTY;
        end
      endcase
`ifdef SCORE_PEAK_HOLD_EN
      // The window-completing average counts as a RUN update.
      if (w_run_next && (w_new_sum[SUM_W-1:WIN_LOG2] > r_peak_sc))
        r_peak_sc <= w_new_sum[SUM_W-1:WIN_LOG2];
`endif
    end
  end

  assign bus.avg_sc    = r_avg_sc;
  assign bus.avg_valid = r_avg_valid;
  assign bus.fill_cnt  = r_fill_cnt;
  assign bus.state     = r_state;

`ifndef SCORE_PEAK_HOLD_EN
  // Only the peak logic consumes the look-ahead flag.
  logic w_unused;
  assign w_unused = w_run_next;
`endif

endmodule

// File: tb/tb_score_averager.sv
module tb_score_averager;
  import driver_monitor_pkg::*;

  localparam int SC_W     = 8;
  localparam int WIN_LOG2 = 3;
  localparam int N        = 1 << WIN_LOG2;

  logic clk;
  logic rst;

  score_averager_if #(.SC_W(SC_W), .WIN_LOG2(WIN_LOG2)) bus ();

  score_averager #(.SC_W(SC_W), .WIN_LOG2(WIN_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [SC_W-1:0] exp_q[$];

  int m_buf [N];
  int m_ptr;
  int m_sum;
  int m_cnt;

  function automatic void model_flush();
    for (int i = 0; i < N; i++) m_buf[i] = 0;
    m_ptr = 0;
    m_sum = 0;
    m_cnt = 0;
    exp_q.delete();
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one accepted sample; push the expected average; return #1 after the edge.
  task automatic drive_sample(input logic [SC_W-1:0] v);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_sc    = v;
    m_sum = m_sum + int'(v) - m_buf[m_ptr];
    m_buf[m_ptr] = int'(v);
    m_ptr = (m_ptr + 1) % N;
    if (m_cnt < N) m_cnt++;
    exp_q.push_back(SC_W'(m_sum / N));
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    model_flush();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.clear = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_sc = '0;
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.avg_sc !== 8'd0) $display("FAIL reset_avg: got %0d want 0", bus.avg_sc);
    else n_pass++;
    n_checks++;
    if (bus.avg_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.avg_valid);
    else n_pass++;
    n_checks++;
    if (bus.fill_cnt !== 4'd0) $display("FAIL reset_fill: got %0d want 0", bus.fill_cnt);
    else n_pass++;
    n_checks++;
    if (bus.state !== EMPTY) $display("FAIL reset_state: got %0d want %0d", bus.state, EMPTY);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
    n_checks++;
    if (bus.avg_sc !== 8'd0 || bus.fill_cnt !== 4'd0)
      $display("FAIL reset_release: avg %0d fill %0d want 0 0", bus.avg_sc, bus.fill_cnt);
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [SC_W-1:0] e;
    for (int i = 0; i < N; i++) begin
      drive_sample(8'd80);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.avg_sc !== e || e !== SC_W'(10 * (i + 1)))
        $display("FAIL fill_avg[%0d]: got %0d want %0d", i, bus.avg_sc, 10 * (i + 1));
      else n_pass++;
      n_checks++;
      if (bus.avg_valid !== (i == N - 1))
        $display("FAIL fill_valid[%0d]: got %b want %b", i, bus.avg_valid, (i == N - 1));
      else n_pass++;
      n_checks++;
      if (bus.fill_cnt !== 4'(m_cnt))
        $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, bus.fill_cnt, m_cnt);
      else n_pass++;
    end
    n_checks++;
    if (bus.state !== RUN) $display("FAIL fill_state: got %0d want %0d", bus.state, RUN);
    else n_pass++;
  endtask

  task automatic test_slide();
    logic [SC_W-1:0] e;
    for (int i = 0; i < N; i++) begin
      drive_sample(8'd160);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.avg_sc !== e) $display("FAIL slide_avg[%0d]: got %0d want %0d", i, bus.avg_sc, e);
      else n_pass++;
      n_checks++;
      if (bus.avg_valid !== 1'b1 || bus.fill_cnt !== 4'd8)
        $display("FAIL slide_flags[%0d]: valid %b fill %0d want 1 8", i, bus.avg_valid, bus.fill_cnt);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (bus.avg_sc !== 8'd120) $display("FAIL slide_half: got %0d want 120", bus.avg_sc);
        else n_pass++;
      end
    end
    n_checks++;
    if (bus.avg_sc !== 8'd160) $display("FAIL slide_full: got %0d want 160", bus.avg_sc);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [SC_W-1:0] e;
    for (int i = 0; i < N; i++) begin
      drive_sample(8'd255);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.avg_sc !== e) $display("FAIL sat_avg[%0d]: got %0d want %0d", i, bus.avg_sc, e);
      else n_pass++;
    end
    n_checks++;
    if (bus.avg_sc !== 8'd255) $display("FAIL sat_max: got %0d want 255", bus.avg_sc);
    else n_pass++;
    drive_sample(8'd0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.avg_sc !== e || e !== 8'd223) $display("FAIL sat_drop: got %0d want 223", bus.avg_sc);
    else n_pass++;
  endtask

  task automatic test_clear_wins();
    logic [SC_W-1:0] e;
    @(negedge clk);
    bus.clear        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_sc    = 8'd200;
    @(posedge clk);
    #1;
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    model_flush();
    n_checks++;
    if (bus.avg_sc !== 8'd0 || bus.avg_valid !== 1'b0 || bus.fill_cnt !== 4'd0)
      $display("FAIL clear_outputs: avg %0d valid %b fill %0d want 0 0 0",
               bus.avg_sc, bus.avg_valid, bus.fill_cnt);
    else n_pass++;
    n_checks++;
    if (bus.state !== EMPTY) $display("FAIL clear_state: got %0d want %0d", bus.state, EMPTY);
    else n_pass++;
    drive_sample(8'd8);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.avg_sc !== e || e !== 8'd1)
      $display("FAIL clear_dropped: got %0d want 1", bus.avg_sc);
    else n_pass++;
    n_checks++;
    if (bus.fill_cnt !== 4'd1) $display("FAIL clear_fill: got %0d want 1", bus.fill_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midgap();
    logic [SC_W-1:0] e;
    drive_clear();
    for (int s = 0; s < 3; s++) begin
      drive_sample(8'd64);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.avg_sc !== e || e !== SC_W'(8 * (s + 1)))
        $display("FAIL gap_avg[%0d]: got %0d want %0d", s, bus.avg_sc, 8 * (s + 1));
      else n_pass++;
      for (int g = 0; g < ((s < 2) ? 5 : 2); g++) begin
        idle_cycle();
        n_checks++;
        if (bus.avg_sc !== e) $display("FAIL gap_hold[%0d.%0d]: got %0d want %0d", s, g, bus.avg_sc, e);
        else n_pass++;
      end
    end
    // Asynchronous reset between edges; outputs must drop before the next edge.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_flush();
    n_checks++;
    if (bus.avg_sc !== 8'd0 || bus.avg_valid !== 1'b0 || bus.fill_cnt !== 4'd0)
      $display("FAIL async_reset: avg %0d valid %b fill %0d want 0 0 0",
               bus.avg_sc, bus.avg_valid, bus.fill_cnt);
    else n_pass++;
`ifdef SCORE_PEAK_HOLD_EN
    n_checks++;
    if (bus.peak_sc !== 8'd0) $display("FAIL async_reset_peak: got %0d want 0", bus.peak_sc);
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b1;
    drive_sample(8'd64);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.avg_sc !== e || e !== 8'd8) $display("FAIL after_reset: got %0d want 8", bus.avg_sc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [SC_W-1:0] e;
    logic [SC_W-1:0] v;
    for (int i = 0; i < 20; i++) begin
      v = SC_W'($urandom_range(0, 255));
      drive_sample(v);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.avg_sc !== e) $display("FAIL b2b_avg[%0d]: got %0d want %0d", i, bus.avg_sc, e);
      else n_pass++;
      n_checks++;
      if (bus.avg_valid !== (m_cnt == N))
        $display("FAIL b2b_valid[%0d]: got %b want %b", i, bus.avg_valid, (m_cnt == N));
      else n_pass++;
    end
  endtask

`ifdef SCORE_PEAK_HOLD_EN
  task automatic test_peak_hold();
    logic [SC_W-1:0] e;
    drive_clear();
    n_checks++;
    if (bus.peak_sc !== 8'd0) $display("FAIL peak_cleared: got %0d want 0", bus.peak_sc);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      drive_sample(8'd100);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.peak_sc !== ((i == N - 1) ? 8'd100 : 8'd0))
        $display("FAIL peak_fill[%0d]: got %0d want %0d", i, bus.peak_sc, (i == N - 1) ? 100 : 0);
      else n_pass++;
    end
    for (int i = 0; i < N; i++) begin
      drive_sample(8'd40);
      e = exp_q.pop_front();
    end
    n_checks++;
    if (bus.avg_sc !== 8'd40 || e !== 8'd40) $display("FAIL peak_avg: got %0d want 40", bus.avg_sc);
    else n_pass++;
    n_checks++;
    if (bus.peak_sc !== 8'd100) $display("FAIL peak_hold: got %0d want 100", bus.peak_sc);
    else n_pass++;
    drive_clear();
    n_checks++;
    if (bus.peak_sc !== 8'd0) $display("FAIL peak_clear: got %0d want 0", bus.peak_sc);
    else n_pass++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill();
    test_slide();
    test_saturate();
    test_clear_wins();
    test_reset_midgap();
    test_back_to_back();
`ifdef SCORE_PEAK_HOLD_EN
    test_peak_hold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/score_averager.md
Name: score_averager

Overview:
- Upstream stage of the driver-monitor safety FSM.
- Accepts per-sample drowsiness scores (8-bit) with a valid strobe and maintains a moving average over a power-of-two window.
- Presents the registered result as avg_sc, which the safety FSM compares against its warning and emergency thresholds.
- Drives an avg_valid flag so the downstream stage can ignore the zero-padded start-up ramp.

Parameters:
- SC_W, 8: score width in bits. avg_sc is always SC_W bits.
- WIN_LOG2, 3: log2 of the window length. N = 2^WIN_LOG2 samples (default 8). Legal range is 1..6.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous flush of the window, active high.
- sample_valid, input, 1: sample_sc is valid this cycle.
- sample_sc, input, SC_W: new instantaneous score.
- avg_sc, output, SC_W: registered moving average, sent to the safety FSM.
- avg_valid, output, 1: high once N samples have been accepted since reset or clear.
- fill_cnt, output, WIN_LOG2+1: number of samples in the window, saturating at N.

Behaviour:
- Reset (rst=0, asynchronous): buffer entries, write pointer, sum, avg_sc, fill_cnt and avg_valid all go to 0; state goes to EMPTY. Reset mid-operation discards all history immediately.
- Storage: ring buffer of N entries, SC_W bits each, plus write pointer wr_ptr (WIN_LOG2 bits).
  - wr_ptr wraps from N-1 to 0 with no special case.
- Accumulator: sum is SC_W+WIN_LOG2 bits wide and can never overflow (worst case N*255).
- On an accepted sample (sample_valid=1, clear=0):
  - old = buf[wr_ptr], which is 0 for slots not yet written;
  - sum <= sum + sample_sc - old;
  - buf[wr_ptr] <= sample_sc;
  - wr_ptr <= wr_ptr+1.
- Output: avg_sc <= (sum + sample_sc - old) >> WIN_LOG2, i.e. truncating division.
  - Latency: one clock from the sample_valid edge to the updated avg_sc.
- No sample: all state holds and avg_sc holds its last value.
- Start-up ramp: before the window is full, the sum is still divided by N (zero padding), so avg_sc ramps up while avg_valid=0.
- State machine:
  - EMPTY: fill_cnt=0. Accepted sample goes to FILL (or straight to RUN when N=1, which is not a legal configuration).
  - FILL: fill_cnt increments on each accepted sample. The sample that makes fill_cnt=N moves to RUN, and avg_valid rises in the same edge as the corresponding avg_sc.
  - RUN: fill_cnt stays at N and avg_valid=1.
  - clear in any state returns to EMPTY.
- clear: on the next edge, zeroes the buffer, sum, wr_ptr, fill_cnt, avg_sc and avg_valid.
  - clear and sample_valid in the same cycle: clear wins and the sample is dropped.
- Outputs are purely registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro SCORE_PEAK_HOLD_EN.
- Defined: adds output peak_sc (SC_W). peak_sc <= max(peak_sc, new avg_sc) on every avg_sc update made while in RUN. It resets and clears to 0 and is not updated during FILL.
- Undefined: the peak_sc port and its register do not exist; all other behaviour is identical.

Decomposition:
- Shared package driver_monitor_pkg holds:
  - SC_W default;
  - WIN_LOG2 default;
  - state encodings for score_averager: EMPTY=2'b00, FILL=2'b01, RUN=2'b10.
- The safety FSM imports SC_W from the same package.
- One natural sub-module: score_ring_buf. It owns the N x SC_W storage, wr_ptr, wrap logic and clear, and returns old.
- score_averager keeps the accumulator, the FSM, the output registers and the optional peak logic.

Test Plan (all at default N=8, SC_W=8):
1. Reset, then 8 consecutive samples of 80 -> avg_sc steps 10,20,...,80, one cycle after each sample; avg_valid=0 until the edge after the 8th sample, then 1; fill_cnt=8.
2. Continue from 1 with samples of 160 -> after 4 new samples avg_sc=120, after 8 new samples avg_sc=160; avg_valid stays 1 throughout.
3. 8 samples of 255 -> sum=2040 with no overflow and avg_sc=255. Then 1 sample of 0 -> avg_sc=223 (1785>>3).
4. In RUN, assert clear and sample_valid (sample 200) in the same cycle -> next edge shows avg_sc=0, avg_valid=0, fill_cnt=0, and sample 200 is absent from later averages.
5. Feed 3 samples of 64 with 5-cycle gaps, then pulse rst low mid-gap -> avg_sc 8,16,24 holding between samples; during rst low all outputs are 0 asynchronously; the next sample after release gives avg_sc=8.
6. With SCORE_PEAK_HOLD_EN defined, fill with 100s, then feed 8 samples of 40 -> peak_sc=100 and avg_sc=40. Then clear -> peak_sc=0.
